std_sdiv_arbiter: RTL

- Shares one iterative signed divider/modulo unit among NREQ requesters, using round-robin arbitration.
- Each requester uses the standard go/done handshake: hold go until done, done pulses for one cycle.
- Produces quotient and remainder together, with SystemVerilog truncating semantics, so one unit serves both sdiv and smod cells.
- Sits between several compiler-generated groups and a single area-expensive divider.

---
 rtl/std_sdiv_arbiter_pkg.sv | 38 +++
 rtl/std_sdiv_arbiter_if.sv | 16 +
 rtl/std_sdiv_arbiter_udiv_iter.sv | 45 ++++
 rtl/std_sdiv_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/std_sdiv_arbiter_pkg.sv
// Shared types and the round-robin winner search for the shared signed divider arbiter.
package sdiv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requester vectors are zero-extended to this width, which caps NREQ at 32.
  localparam int MAX_NREQ = 32;
  localparam int RR_IDX_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First unmasked requester at or after ptr+1, wrapping modulo nreq.
  function automatic rr_pick_t rr_next(input logic [MAX_NREQ-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input logic [MAX_NREQ-1:0] mask,
                                       input int unsigned         nreq);
    rr_pick_t    p;
    int unsigned c;
    p = '0;
    for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
      c = 32'(ptr) + k;
      if (c >= nreq) c = c - nreq;
      if (k <= nreq && !p.found && req[c[RR_IDX_W-1:0]] && !mask[c[RR_IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = c[RR_IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/std_sdiv_arbiter_if.sv
// Requester-side bus of the shared signed divider: packed per-requester operands and handshake.
interface std_sdiv_arbiter_if #(
  parameter int width = 32,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       go;
  logic [NREQ*width-1:0] left;
  logic [NREQ*width-1:0] right;
  logic [width-1:0]      quotient;
  logic [width-1:0]      remainder;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       grant;

  modport master (output go, left, right, input quotient, remainder, done, grant);
  modport slave  (input go, left, right, output quotient, remainder, done, grant);
endinterface

// File: rtl/std_sdiv_arbiter_udiv_iter.sv
// Unsigned restoring divider core, one quotient bit per step, MSB first.
module std_udiv_iter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [width-1:0] dvd_i,
  input  logic [width-1:0] dvs_i,
  output logic [width-1:0] qmag_o,
  output logic [width-1:0] rmag_o,
  output logic             last_o
);
  localparam int CW = (width > 1) ? $clog2(width) : 1;

  logic [width-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [width:0]   trial;
  logic [width-1:0] diff;
  logic             ge;

  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    trial  = {rem_q, quo_q[width-1]};
    ge     = (trial >= {1'b0, dvs_q});
    diff   = trial[width-1:0] - dvs_q;
    rmag_o = ge ? diff : trial[width-1:0];
    qmag_o = {quo_q[width-2:0], ge};
    last_o = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= dvd_i;
      dvs_q <= dvs_i;
      cnt_q <= CW'(width - 1);
    end else if (step_i) begin
      rem_q <= rmag_o;
      quo_q <= qmag_o;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/std_sdiv_arbiter.sv
// Round-robin arbiter sharing one iterative signed divide/modulo unit among NREQ requesters.
module std_sdiv_arbiter
  import sdiv_arb_pkg::*;
#(
  parameter int width = 32,
  parameter int NREQ  = 2
) (
  input  logic              clk,
  input  logic              reset,
  std_sdiv_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d, done_q, done_d, mask_q, mask_d;
  logic [RR_IDX_W-1:0] ptr_q, ptr_d;
  logic                qsign_q, qsign_d, lsign_q, lsign_d;
  logic [width-1:0]    quo_q, quo_d, rem_q, rem_d;

  rr_pick_t                pick;
  logic signed [width-1:0] left_w, right_w;
  logic [width-1:0]        dvd_mag, dvs_mag, core_q, core_r;
  logic                    core_start, core_step, core_last, owner_go;

  // Magnitude as unsigned, so the most negative value maps to 2^(width-1).
  function automatic logic [width-1:0] mag(input logic signed [width-1:0] x);
    logic [width-1:0] u;
    u = x;
    return u[width-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [width-1:0] sfix(input logic neg, input logic [width-1:0] m);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign pick     = rr_next(MAX_NREQ'(bus.go), ptr_q, MAX_NREQ'(mask_q), NREQ);
  assign left_w   = bus.left[int'(pick.idx)*width +: width];
  assign right_w  = bus.right[int'(pick.idx)*width +: width];
  assign dvd_mag  = mag(left_w);
  assign dvs_mag  = mag(right_w);
  assign owner_go = |(bus.go & grant_q);

  std_udiv_iter #(.width(width)) u_core (
    .clk     (clk),
    .start_i (core_start),
    .step_i  (core_step),
    .dvd_i   (dvd_mag),
    .dvs_i   (dvs_mag),
    .qmag_o  (core_q),
    .rmag_o  (core_r),
    .last_o  (core_last)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    mask_d     = '0;
    done_d     = '0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    qsign_d    = qsign_q;
    lsign_d    = lsign_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick.found) begin
          grant_d    = NREQ'(1) << pick.idx;
          ptr_d      = pick.idx;
          lsign_d    = left_w[width-1];
          qsign_d    = left_w[width-1] ^ right_w[width-1];
          core_start = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!owner_go) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          core_step = 1'b1;
          if (core_last) begin
            state_d = DONE;
            done_d  = grant_q;
            quo_d   = sfix(qsign_q, core_q);
            rem_d   = sfix(lsign_q, core_r);
          end
        end
      end
      DONE: begin
        // The finishing owner still holds go for a cycle; keep it out of the next search.
        state_d = IDLE;
        grant_d = '0;
        mask_d  = grant_q;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= RR_IDX_W'(NREQ - 1);
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    qsign_q <= qsign_d;
    lsign_q <= lsign_d;
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.done      = done_q;
  assign bus.grant     = grant_q;

endmodule
